// File: rtl/async_receive.sv
// async_receive: RS-232 8N1 receiver with oversampled glitch filter,
// framing/break detection and line-idle / end-of-packet indication.
module async_receive #(
  parameter int ClkFrequency = 10000000,
  parameter int Baud = 115200,
  parameter int Oversampling = 8,
  parameter int BaudGeneratorAccWidth = 16,
  parameter int IdleBits = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_framing_error,
  output logic       RxD_idle,
  output logic       RxD_endofpacket
);
  localparam int W = BaudGeneratorAccWidth;
  localparam longint IncL = (((longint'(Baud) * Oversampling) << (W - 7)) + (ClkFrequency >> 8)) / (ClkFrequency >> 7);
  localparam logic [W:0] Inc = (W + 1)'(IncL);
  localparam int SW = $clog2(Oversampling);
  localparam logic [SW-1:0] Mid = SW'(Oversampling / 2);
  localparam int GapMax = IdleBits * Oversampling;
  localparam int GW = $clog2(GapMax + 1);
  localparam logic [GW-1:0] Sat = GW'(GapMax);
  typedef enum logic [3:0] {IDLE, START, BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7, STOP, BRK} state_t;
  logic [W:0] acc;
  logic [1:0] sync, cnt, cnt_n;
  logic filt, tick, mid;
  state_t state;
  logic [SW-1:0] spacing;
  logic [7:0] shift;
  logic [GW-1:0] gap;
  always_comb begin
    tick = acc[W];
    mid = spacing == Mid;
    RxD_idle = gap == Sat;
    cnt_n = sync[1] ? (&cnt ? cnt : cnt + 2'd1) : (|cnt ? cnt - 2'd1 : cnt);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      sync <= 2'b11;
      cnt <= 2'b11;
      filt <= 1'b1;
      state <= IDLE;
      spacing <= '0;
      shift <= '0;
      gap <= Sat;
      RxD_data <= '0;
      RxD_data_ready <= 1'b0;
      RxD_framing_error <= 1'b0;
      RxD_endofpacket <= 1'b0;
    end else begin
      acc <= {1'b0, acc[W-1:0]} + Inc;
      sync <= {sync[0], RxD};
      RxD_data_ready <= 1'b0;
      RxD_framing_error <= 1'b0;
      RxD_endofpacket <= 1'b0;
      gap <= (state != IDLE || !filt) ? '0 : (tick && !RxD_idle) ? gap + 1'b1 : gap;
      if (tick) begin
        cnt <= cnt_n;
        filt <= cnt_n == 2'b11 ? 1'b1 : cnt_n == 2'b00 ? 1'b0 : filt;
        spacing <= state == IDLE ? '0 : spacing + 1'b1;
        RxD_endofpacket <= state == IDLE && filt && gap == Sat - 1'b1;
        case (state)
          IDLE: if (!filt) state <= START;
          START: if (mid) state <= filt ? IDLE : BIT0;
          STOP: if (mid) begin
            if (filt) begin
              RxD_data <= shift;
              RxD_data_ready <= 1'b1;
              state <= IDLE;
            end else begin
              RxD_framing_error <= 1'b1;
              state <= shift == 8'h00 ? BRK : IDLE;
            end
          end
          BRK: if (filt) state <= IDLE;
          default: if (mid) begin
            shift <= {filt, shift[7:1]};
            state <= state_t'(state + 1'b1);
          end
        endcase
      end
    end
endmodule

// File: doc/async_receive.md
Name: async_receive

Overview:
- RS-232 8N1 receiver; the receive-side counterpart of the UART transmitter in the serial debug/console path.
- Oversamples the asynchronous RxD line with a fractional accumulator baud generator and filters glitches.
- Validates the start bit, samples the 8 data bits (LSB first) mid-bit, and checks the stop bit.
- Presents each received byte with a one-cycle strobe, a framing-error strobe, and line-idle / end-of-packet indications for the packet parser downstream.

Parameters:
- ClkFrequency, 10000000, system clock in Hz.
- Baud, 115200, serial bit rate.
- Oversampling, 8, baud ticks per bit; power of two, 8 or 16 only.
- BaudGeneratorAccWidth, 16, fractional accumulator width.
- IdleBits, 16, consecutive high bit-times before RxD_idle asserts.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous active-high reset.
- RxD  in  1  serial input, asynchronous to clk, idle high.
- RxD_data  out  8  last correctly framed byte; held until the next good byte.
- RxD_data_ready  out  1  one-cycle pulse when RxD_data updates.
- RxD_framing_error  out  1  one-cycle pulse when the stop bit is sampled low.
- RxD_idle  out  1  high while the line has been idle for IdleBits bit-times.
- RxD_endofpacket  out  1  one-cycle pulse on the rising edge of RxD_idle.

Behaviour:
- Reset is asynchronous and active-high; every register below takes its reset value immediately on reset assertion.
- Reset values: RxD_data=0, RxD_data_ready=0, RxD_framing_error=0, RxD_idle=1, RxD_endofpacket=0. Synchronizer and filter are preset to 1, state=IDLE, gap counter saturated.
- Reset mid-frame abandons the byte with no strobe.
- Baud tick generator:
  - Inc = ((Baud*Oversampling) << (W-7) + (ClkFrequency>>8)) / (ClkFrequency>>7), where W=BaudGeneratorAccWidth.
  - Each clk: Acc <= Acc[W-1:0] + Inc. Tick = Acc[W], one clk wide.
  - Free-running; never gated by state.
- Input conditioning:
  - 2-flop synchronizer on RxD.
  - 2-bit saturating counter updated on tick only: increment if sync=1, decrement if sync=0.
  - Filtered bit goes to 1 when the counter reaches 3 and to 0 when it reaches 0; otherwise it holds.
- Bit timing: a log2(Oversampling)-bit spacing counter advances on tick. A sample is taken when spacing equals Oversampling/2.
- State machine (all transitions on tick only):
  - IDLE: filtered bit = 0 -> START, spacing cleared.
  - START: at mid-bit, filtered = 0 -> BIT0; filtered = 1 -> IDLE (glitch rejected, no strobe).
  - BIT0..BIT7: at mid-bit, shift the filtered bit into shift[7] (shift right, so LSB lands in [0]), then go to the next state. BIT7 -> STOP.
  - STOP, mid-bit, filtered = 1: RxD_data <= shift; RxD_data_ready pulses on the next clk; -> IDLE.
  - STOP, mid-bit, filtered = 0: RxD_framing_error pulses; RxD_data is unchanged. If shift == 0 (break) -> BREAK, else -> IDLE.
  - BREAK: stay until filtered = 1, then -> IDLE. No further strobes during the break.
- Strobes are exactly one clk wide, never both in the same cycle, and never repeat within one frame.
- Latency: the data_ready pulse lands 1 clk after the tick at mid-stop-bit, about 9.5 bit-times after the start edge plus 2-3 clk of synchronizer and filter delay.
- Idle detection:
  - Gap counter (ticks) clears while state != IDLE or filtered = 0.
  - It increments on tick in IDLE with filtered = 1, and saturates at IdleBits*Oversampling.
  - RxD_idle = counter saturated.
  - RxD_endofpacket pulses on the 0->1 transition of RxD_idle, except the first after reset, since the counter starts saturated.
- Back-to-back frames: a start bit beginning immediately after the mid-stop sample must be caught. IDLE re-arms the same tick it is entered.

Test Plan:
- Byte 0x55: bench uses ClkFrequency=1843200, Baud=115200, so Inc=32768, a tick every 2 clk, and 16 clk per bit. Send 0x55 -> exactly one RxD_data_ready pulse, RxD_data=0x55, no framing error.
- Back-to-back: send 0x00, 0xFF, 0xA5 with no gap -> three ready pulses, data 0x00, 0xFF, 0xA5 in order. RxD_idle stays 0 between bytes; one RxD_endofpacket pulse 256 clk (16 bits × 16 clk) after the last stop bit.
- Glitch rejection: a 3-clk low pulse on idle RxD -> no strobes, state returns to IDLE. A 1-clk low glitch inside data bit 3 of 0x0F -> byte still 0x0F.
- Framing error: send 0x3C with the stop bit driven low -> RxD_framing_error pulses once, RxD_data keeps the previous 0x55, no ready pulse.
- Break: hold RxD low for 30 bit-times, then release and send 0x81 -> one framing-error pulse only, then a ready pulse with 0x81.
- Mid-frame reset: assert reset during bit 4 of 0x77, then release and send 0x12 -> all outputs at reset values during reset, no strobe for 0x77, 0x12 received correctly.
